// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer for a small accumulator CPU: fetch, decode, operand access, execute.
// Outputs decode the registered state combinationally; memory waits are bounded by WAIT_MAX and time out to HALT.
module ctrl_sequencer #(
  parameter int BITS     = 8,
  parameter int ALU_BITS = 2,
  parameter int WAIT_MAX = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [BITS-1:0]     i_opcode,
  input  logic                i_acc_zero,
  input  logic                i_run,
  input  logic                i_mem_ready,
  output logic                o_ld_mar,
  output logic                o_ld_mdr,
  output logic                o_ld_ir,
  output logic                o_ld_pc,
  output logic                o_ld_acc,
  output logic                o_mem_rd,
  output logic                o_mem_wr,
  output logic                o_mux_pc_ird,
  output logic                o_mux_ir_p1,
  output logic                o_mux_mdr_alur,
  output logic [ALU_BITS-1:0] o_alu_ctrl,
  output logic                o_halted,
  output logic                o_bus_err,
  output logic                o_illegal,
  output logic [3:0]          o_state
);

  typedef enum logic [3:0] {
    S_FETCH_ADDR = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_OPER_ADDR  = 4'd3,
    S_MEM_WAIT   = 4'd4,
    S_EXEC       = 4'd5,
    S_INC_PC     = 4'd6,
    S_JUMP       = 4'd7,
    S_HALT       = 4'd8
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_STA = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JZ  = 4'd6;
  localparam logic [3:0] OP_HLT = 4'd7;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       bus_err_q, bus_err_d;
  logic [3:0] op_in;
  logic       wait_expired;

  assign op_in = i_opcode[BITS-1:BITS-4];

  generate
    if (BITS > 4) begin : g_operand
      logic unused_operand;
      assign unused_operand = ^i_opcode[BITS-5:0];
    end
  endgenerate

  // wcnt_q holds the number of wait cycles already elapsed, so this is wait cycle WAIT_MAX
  assign wait_expired = (wcnt_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wcnt_d    = wcnt_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH_ADDR: begin
        wcnt_d = 8'd0;
        if (i_run) state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (i_mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        op_d = op_in;
        case (op_in)
          OP_NOP:                         state_d = S_INC_PC;
          OP_LDA, OP_STA, OP_ADD, OP_SUB: state_d = S_OPER_ADDR;
          OP_JMP:                         state_d = S_JUMP;
          OP_JZ:                          state_d = i_acc_zero ? S_JUMP : S_INC_PC;
          OP_HLT:                         state_d = S_HALT;
          default:                        state_d = S_INC_PC;
        endcase
      end
      S_OPER_ADDR: begin
        wcnt_d  = 8'd0;
        state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (i_mem_ready) begin
          state_d = (op_q == OP_STA) ? S_INC_PC : S_EXEC;
        end else if (wait_expired) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_EXEC:   state_d = S_INC_PC;
      S_INC_PC: state_d = S_FETCH_ADDR;
      S_JUMP:   state_d = S_FETCH_ADDR;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH_ADDR;
      op_q      <= 4'd0;
      wcnt_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wcnt_q    <= wcnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    o_ld_mar       = 1'b0;
    o_ld_mdr       = 1'b0;
    o_ld_ir        = 1'b0;
    o_ld_pc        = 1'b0;
    o_ld_acc       = 1'b0;
    o_mem_rd       = 1'b0;
    o_mem_wr       = 1'b0;
    o_mux_pc_ird   = 1'b0;
    o_mux_ir_p1    = 1'b0;
    o_mux_mdr_alur = 1'b0;
    o_alu_ctrl     = '0;
    o_halted       = 1'b0;
    o_illegal      = 1'b0;
    o_state        = state_q;
    case (state_q)
      S_FETCH_ADDR: o_ld_mar = i_run;
      S_FETCH_WAIT: begin
        o_mem_rd = 1'b1;
        o_ld_ir  = i_mem_ready;
      end
      S_DECODE:    o_illegal = op_in[3];
      S_OPER_ADDR: begin
        o_ld_mar     = 1'b1;
        o_mux_pc_ird = 1'b1;
      end
      S_MEM_WAIT: begin
        o_mem_wr = (op_q == OP_STA);
        o_mem_rd = (op_q != OP_STA);
        o_ld_mdr = i_mem_ready && (op_q != OP_STA);
      end
      S_EXEC: begin
        o_ld_acc       = 1'b1;
        o_mux_mdr_alur = (op_q == OP_ADD) || (op_q == OP_SUB);
        if (op_q == OP_SUB) o_alu_ctrl = ALU_BITS'(1);
      end
      S_INC_PC: o_ld_pc = 1'b1;
      S_JUMP: begin
        o_ld_pc     = 1'b1;
        o_mux_ir_p1 = 1'b1;
      end
      S_HALT:  o_halted = 1'b1;
      default: ;
    endcase
    // The registered state may still be mid-access while reset is low; keep everything quiet
    if (!i_rst_n) begin
      o_ld_mar       = 1'b0;
      o_ld_mdr       = 1'b0;
      o_ld_ir        = 1'b0;
      o_ld_pc        = 1'b0;
      o_ld_acc       = 1'b0;
      o_mem_rd       = 1'b0;
      o_mem_wr       = 1'b0;
      o_mux_pc_ird   = 1'b0;
      o_mux_ir_p1    = 1'b0;
      o_mux_mdr_alur = 1'b0;
      o_alu_ctrl     = '0;
      o_halted       = 1'b0;
      o_illegal      = 1'b0;
      o_state        = 4'd0;
    end
  end

  assign o_bus_err = bus_err_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: per-cycle state and output-vector checks against hand-written expectations.
module tb_ctrl_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_acc_zero, i_run, i_mem_ready;
  logic [7:0] i_opcode;
  logic       o_ld_mar, o_ld_mdr, o_ld_ir, o_ld_pc, o_ld_acc, o_mem_rd, o_mem_wr;
  logic       o_mux_pc_ird, o_mux_ir_p1, o_mux_mdr_alur, o_halted, o_bus_err, o_illegal;
  logic [1:0] o_alu_ctrl;
  logic [3:0] o_state;
  logic [14:0] obs;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [14:0] LDMAR = 15'h4000, LDMDR = 15'h2000, LDIR = 15'h1000, LDPC = 15'h0800;
  localparam logic [14:0] LDACC = 15'h0400, RD = 15'h0200, WR = 15'h0100, MPC = 15'h0080;
  localparam logic [14:0] MIR = 15'h0040, MALU = 15'h0020, ASUB = 15'h0008;
  localparam logic [14:0] HLT = 15'h0004, BERR = 15'h0002, ILL = 15'h0001, NONE = 15'h0000;

  always #5 i_clk = ~i_clk;

  ctrl_sequencer #(.BITS(8), .ALU_BITS(2), .WAIT_MAX(15)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_acc_zero(i_acc_zero),
    .i_run(i_run), .i_mem_ready(i_mem_ready),
    .o_ld_mar(o_ld_mar), .o_ld_mdr(o_ld_mdr), .o_ld_ir(o_ld_ir), .o_ld_pc(o_ld_pc),
    .o_ld_acc(o_ld_acc), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
    .o_mux_pc_ird(o_mux_pc_ird), .o_mux_ir_p1(o_mux_ir_p1), .o_mux_mdr_alur(o_mux_mdr_alur),
    .o_alu_ctrl(o_alu_ctrl), .o_halted(o_halted), .o_bus_err(o_bus_err),
    .o_illegal(o_illegal), .o_state(o_state)
  );

  assign obs = {o_ld_mar, o_ld_mdr, o_ld_ir, o_ld_pc, o_ld_acc, o_mem_rd, o_mem_wr,
                o_mux_pc_ird, o_mux_ir_p1, o_mux_mdr_alur, o_alu_ctrl, o_halted, o_bus_err, o_illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are set one step after the rising edge; outputs are checked one step later, then advance a cycle
  task automatic cyc(input string tag, input logic [3:0] st, input logic [14:0] ov);
    #1;
    check({tag, ".state"}, 32'(o_state), 32'(st));
    check({tag, ".outs"}, 32'(obs), 32'(ov));
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_run = 1'b1; i_mem_ready = 1'b1; i_acc_zero = 1'b0; i_opcode = 8'h00;
    @(posedge i_clk); #1;
    cyc("rst_hold", 4'd0, NONE);
    check("rst_berr", 32'(o_bus_err), 32'd0);
    i_rst_n = 1'b1;

    // NOP: 0,1,2,6,0
    cyc("nop0", 4'd0, LDMAR);
    cyc("nop1", 4'd1, RD | LDIR);
    cyc("nop2", 4'd2, NONE);
    cyc("nop3", 4'd6, LDPC);

    // ADD with ready late by 3 cycles in MEM_WAIT: 10 cycles
    i_opcode = 8'h30;
    cyc("add0", 4'd0, LDMAR);
    cyc("add1", 4'd1, RD | LDIR);
    cyc("add2", 4'd2, NONE);
    cyc("add3", 4'd3, LDMAR | MPC);
    i_mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) cyc("add_wait", 4'd4, RD);
    i_mem_ready = 1'b1;
    cyc("add_rdy", 4'd4, RD | LDMDR);
    cyc("add_exec", 4'd5, LDACC | MALU);
    cyc("add_inc", 4'd6, LDPC);

    // SUB, zero wait: 7 cycles
    i_opcode = 8'h4F;
    cyc("sub0", 4'd0, LDMAR);
    cyc("sub1", 4'd1, RD | LDIR);
    cyc("sub2", 4'd2, NONE);
    cyc("sub3", 4'd3, LDMAR | MPC);
    cyc("sub4", 4'd4, RD | LDMDR);
    cyc("sub_exec", 4'd5, LDACC | MALU | ASUB);
    cyc("sub_inc", 4'd6, LDPC);

    // LDA with extra fetch waits, then ready on the last allowed MEM_WAIT cycle
    i_opcode = 8'h10;
    cyc("lda0", 4'd0, LDMAR);
    i_mem_ready = 1'b0;
    cyc("lda_fw", 4'd1, RD);
    cyc("lda_fw", 4'd1, RD);
    i_mem_ready = 1'b1;
    cyc("lda_fr", 4'd1, RD | LDIR);
    cyc("lda2", 4'd2, NONE);
    cyc("lda3", 4'd3, LDMAR | MPC);
    i_mem_ready = 1'b0;
    for (int k = 0; k < 14; k++) cyc("lda_wait", 4'd4, RD);
    i_mem_ready = 1'b1;
    cyc("lda_last", 4'd4, RD | LDMDR);
    cyc("lda_exec", 4'd5, LDACC);
    cyc("lda_inc", 4'd6, LDPC);

    // STA zero wait: 6 cycles, no MDR load
    i_opcode = 8'h2A;
    cyc("sta0", 4'd0, LDMAR);
    cyc("sta1", 4'd1, RD | LDIR);
    cyc("sta2", 4'd2, NONE);
    cyc("sta3", 4'd3, LDMAR | MPC);
    cyc("sta4", 4'd4, WR);
    cyc("sta_inc", 4'd6, LDPC);

    // JMP and JZ taken / not taken
    i_opcode = 8'h50;
    cyc("jmp0", 4'd0, LDMAR);
    cyc("jmp1", 4'd1, RD | LDIR);
    cyc("jmp2", 4'd2, NONE);
    cyc("jmp3", 4'd7, LDPC | MIR);
    i_opcode = 8'h60; i_acc_zero = 1'b1;
    cyc("jzt0", 4'd0, LDMAR);
    cyc("jzt1", 4'd1, RD | LDIR);
    cyc("jzt2", 4'd2, NONE);
    i_acc_zero = 1'b0;
    cyc("jzt3", 4'd7, LDPC | MIR);
    cyc("jzf0", 4'd0, LDMAR);
    cyc("jzf1", 4'd1, RD | LDIR);
    cyc("jzf2", 4'd2, NONE);
    cyc("jzf3", 4'd6, LDPC);

    // Illegal opcode 0xC0: one-cycle pulse then INC_PC
    i_opcode = 8'hC0;
    cyc("ill0", 4'd0, LDMAR);
    cyc("ill1", 4'd1, RD | LDIR);
    cyc("ill2", 4'd2, ILL);
    cyc("ill3", 4'd6, LDPC);

    // i_run low holds FETCH_ADDR; dropping it mid-instruction lets the NOP finish
    i_opcode = 8'h00; i_run = 1'b0;
    for (int k = 0; k < 3; k++) cyc("idle", 4'd0, NONE);
    i_run = 1'b1;
    cyc("run0", 4'd0, LDMAR);
    i_run = 1'b0;
    cyc("run1", 4'd1, RD | LDIR);
    cyc("run2", 4'd2, NONE);
    cyc("run3", 4'd6, LDPC);
    cyc("run_idle", 4'd0, NONE);

    // Reset while in MEM_WAIT
    i_run = 1'b1; i_opcode = 8'h10;
    cyc("rmw0", 4'd0, LDMAR);
    cyc("rmw1", 4'd1, RD | LDIR);
    cyc("rmw2", 4'd2, NONE);
    cyc("rmw3", 4'd3, LDMAR | MPC);
    i_mem_ready = 1'b0;
    cyc("rmw4", 4'd4, RD);
    i_rst_n = 1'b0;
    cyc("rmw_rst", 4'd0, NONE);
    i_rst_n = 1'b1; i_mem_ready = 1'b1;
    cyc("rmw_after", 4'd0, LDMAR);

    // STA timeout: 15 write cycles, then bus error and HALT
    i_opcode = 8'h20;
    cyc("to1", 4'd1, RD | LDIR);
    cyc("to2", 4'd2, NONE);
    cyc("to3", 4'd3, LDMAR | MPC);
    i_mem_ready = 1'b0;
    for (int k = 0; k < 15; k++) cyc("to_wait", 4'd4, WR);
    cyc("to_halt", 4'd8, HLT | BERR);
    i_mem_ready = 1'b1;
    cyc("to_stay", 4'd8, HLT | BERR);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    cyc("to_rst", 4'd0, NONE);
    i_rst_n = 1'b1;
    cyc("to_clear", 4'd0, LDMAR);

    // HLT holds for 100 cycles whatever i_run does
    i_opcode = 8'h70;
    cyc("hlt1", 4'd1, RD | LDIR);
    cyc("hlt2", 4'd2, NONE);
    for (int k = 0; k < 100; k++) begin
      i_run = k[0];
      cyc("hlt_hold", 4'd8, HLT);
    end
    i_rst_n = 1'b0;
    cyc("hlt_rst", 4'd0, NONE);
    i_rst_n = 1'b1; i_run = 1'b1;
    cyc("hlt_exit", 4'd0, LDMAR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
